// File: rtl/rr_arb_mux_pkg.sv
// Shared defaults, the arbitration mode type and the select one-hot check
// used by the round-robin arbiter/mux.
package rr_arb_mux_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 4;
  localparam int MAX_CH     = 16;

  typedef enum logic {
    MODE_RR     = 1'b0,
    MODE_FORCED = 1'b1
  } mode_e;

  // Callers zero-extend their select vector to MAX_CH bits.
  function automatic logic is_onehot(input logic [MAX_CH-1:0] v);
    return $countones(v) == 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_rr_pick.sv
// Combinational round-robin search: first requester at or above ptr,
// wrapping from NUM_CH-1 back to 0. Grant is one-hot or zero.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbiter/mux with a single registered output beat. Round-robin or
// forced one-hot selection; one beat per cycle under continuous ready.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode_i,
  input  logic [NUM_CH-1:0]        sel_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [NUM_CH-1:0]        out_grant_o,
  input  logic                     out_ready_i,
  output logic                     sel_err_o
);

  localparam int PTR_W = $clog2(NUM_CH);

  mode_e              mode;
  logic               sel_ok;
  logic               load_en;
  logic [NUM_CH-1:0]  rr_grant;
  logic [NUM_CH-1:0]  grant;
  logic               xfer;
  logic [PTR_W-1:0]   xfer_idx;
  logic [DATA_W-1:0]  xfer_data;

  logic [PTR_W-1:0]   ptr_q,       ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q,  out_data_d;
  logic [NUM_CH-1:0]  out_grant_q, out_grant_d;
  logic               sel_err_q,   sel_err_d;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req   (ch_valid_i),
    .ptr   (ptr_q),
    .grant (rr_grant)
  );

  always_comb begin
    mode    = mode_e'(mode_i);
    sel_ok  = is_onehot(MAX_CH'(sel_i));
    load_en = !out_valid_q || out_ready_i;

    grant = '0;
    if (mode == MODE_RR)  grant = rr_grant;
    else if (sel_ok)      grant = sel_i & ch_valid_i;

    // Ready is gated by reset so nothing can handshake while state is cleared.
    ch_ready_o = (reset && load_en) ? grant : '0;
    xfer       = |(ch_ready_o & ch_valid_i);

    xfer_idx  = '0;
    xfer_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_ready_o[k]) begin
        xfer_idx  = PTR_W'(k);
        xfer_data = ch_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_grant_d = out_grant_q;

    if (load_en) out_valid_d = xfer;
    if (xfer) begin
      out_data_d  = xfer_data;
      out_grant_d = ch_ready_o;
      if (mode == MODE_RR)
        ptr_d = (xfer_idx == PTR_W'(NUM_CH - 1)) ? '0 : xfer_idx + PTR_W'(1);
    end

    sel_err_d = (mode == MODE_FORCED) && !sel_ok;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_grant_q <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_grant_q <= out_grant_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_grant_o = out_grant_q;
  assign sel_err_o   = sel_err_q;

endmodule
